// File: rtl/guess_commit_sequencer_pkg.sv
// ============================================================================
// guess_commit_sequencer_pkg : shared board geometry, hint codes, FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package guess_commit_sequencer_pkg;

  localparam int max_pins_count   = 20;
  localparam int max_guesses      = 99;
  localparam int ram_hints_offset = 1980;
  localparam int PIN_COLOR_W      = 5;
  localparam int PIN_POS_W        = 5;
  localparam int RAM_ADDR_W       = 12;

  localparam int HINT_NONE   = 0;
  localparam int HINT_YELLOW = 1;
  localparam int HINT_GREEN  = 2;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_GUESS = 3'd1,
    YELLOW   = 3'd2,
    WR_HINT  = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } gcs_state_e;

endpackage

`default_nettype wire

// File: rtl/guess_commit_sequencer.sv
// ============================================================================
// guess_commit_sequencer : writes a guess row to board RAM, scores it against
// the secret and writes the matching hint row.   Revision: 1.0
// ============================================================================
`default_nettype none

module guess_commit_sequencer
  import guess_commit_sequencer_pkg::*;
#(
  parameter int MAX_PINS  = max_pins_count,
  parameter int COLOR_W   = PIN_COLOR_W,
  parameter int POS_W     = PIN_POS_W,
  parameter int HINTS_OFS = ram_hints_offset
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [POS_W-1:0]              pins_count,
  input  logic [7:0]                    guess_row,
  input  logic [MAX_PINS*COLOR_W-1:0]   guess,
  input  logic [MAX_PINS*COLOR_W-1:0]   secret,
  input  logic                          ram_wr_ready,
  output logic                          ram_wr_en,
  output logic [RAM_ADDR_W-1:0]         ram_wr_addr,
  output logic [COLOR_W-1:0]            ram_wr_data,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [POS_W-1:0]              green,
  output logic [POS_W-1:0]              yellow,
  output logic                          win
);

  gcs_state_e                  r_state;
  gcs_state_e                  w_state_next;
  logic [MAX_PINS*COLOR_W-1:0] r_guess;
  logic [MAX_PINS*COLOR_W-1:0] r_secret;
  logic [RAM_ADDR_W-1:0]       r_row_base;
  logic [POS_W-1:0]            r_n;
  logic [POS_W-1:0]            r_i;
  logic [POS_W-1:0]            r_j;
  logic [POS_W-1:0]            r_k;
  logic [POS_W-1:0]            r_green;
  logic [POS_W-1:0]            r_yellow;
  logic [MAX_PINS-1:0]         r_gmask;
  logic [MAX_PINS-1:0]         r_smask;
  logic                        r_win;

  logic [COLOR_W-1:0]          w_gpin [MAX_PINS];
  logic [COLOR_W-1:0]          w_spin [MAX_PINS];
  logic [POS_W-1:0]            w_n;
  logic                        w_row_bad;
  logic                        w_i_last;
  logic                        w_j_last;
  logic                        w_k_last;
  logic                        w_gsame;
  logic                        w_ymatch;
  logic                        w_y_adv_i;
  logic [POS_W:0]              w_gy_sum;

  generate
    for (genvar p = 0; p < MAX_PINS; p++) begin : g_unpack
      assign w_gpin[p] = r_guess[p*COLOR_W +: COLOR_W];
      assign w_spin[p] = r_secret[p*COLOR_W +: COLOR_W];
    end
  endgenerate

  assign w_n       = (pins_count > POS_W'(MAX_PINS)) ? POS_W'(MAX_PINS) : pins_count;
  assign w_row_bad = (guess_row >= 8'(max_guesses));
  assign w_i_last  = (r_i == r_n - 1'b1);
  assign w_j_last  = (r_j == r_n - 1'b1);
  assign w_k_last  = (r_k == r_n - 1'b1);
  assign w_gsame   = (w_gpin[r_i] == w_spin[r_i]);
  // Secret pins already claimed by a green or an earlier yellow cannot match again
  assign w_ymatch  = !r_smask[r_j] && (w_gpin[r_i] == w_spin[r_j]);
  assign w_y_adv_i = r_gmask[r_i] || w_ymatch || w_j_last;
  assign w_gy_sum  = {1'b0, r_green} + {1'b0, r_yellow};

  assign green  = r_green;
  assign yellow = r_yellow;
  assign win    = r_win;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    ram_wr_en    = 1'b0;
    ram_wr_addr  = '0;
    ram_wr_data  = '0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          if (w_n == '0)     w_state_next = DONE;
          else if (w_row_bad) w_state_next = ERR;
          else               w_state_next = WR_GUESS;
        end
      end
      WR_GUESS: begin
        busy        = 1'b1;
        ram_wr_en   = 1'b1;
        ram_wr_addr = r_row_base + RAM_ADDR_W'(r_i);
        ram_wr_data = w_gpin[r_i];
        if (ram_wr_ready && w_i_last) w_state_next = YELLOW;
      end
      YELLOW: begin
        busy = 1'b1;
        if (w_y_adv_i && w_i_last) w_state_next = WR_HINT;
      end
      WR_HINT: begin
        busy        = 1'b1;
        ram_wr_en   = 1'b1;
        ram_wr_addr = RAM_ADDR_W'(HINTS_OFS) + r_row_base + RAM_ADDR_W'(r_k);
        if (r_k < r_green)               ram_wr_data = COLOR_W'(HINT_GREEN);
        else if ({1'b0, r_k} < w_gy_sum) ram_wr_data = COLOR_W'(HINT_YELLOW);
        else                             ram_wr_data = COLOR_W'(HINT_NONE);
        if (ram_wr_ready && w_k_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      ERR: begin
        err          = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_guess    <= '0;
      r_secret   <= '0;
      r_row_base <= '0;
      r_n        <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_green    <= '0;
      r_yellow   <= '0;
      r_gmask    <= '0;
      r_smask    <= '0;
      r_win      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_guess    <= guess;
            r_secret   <= secret;
            r_n        <= w_n;
            r_row_base <= RAM_ADDR_W'(guess_row) * RAM_ADDR_W'(MAX_PINS);
            r_i        <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_green    <= '0;
            r_yellow   <= '0;
            r_gmask    <= '0;
            r_smask    <= '0;
            r_win      <= (w_n == '0);
          end
        end
        WR_GUESS: begin
          if (ram_wr_ready) begin
            if (w_gsame) begin
              r_gmask[r_i] <= 1'b1;
              r_smask[r_i] <= 1'b1;
              r_green      <= r_green + 1'b1;
            end
            r_i <= w_i_last ? '0 : r_i + 1'b1;
            r_j <= '0;
          end
        end
        YELLOW: begin
          if (r_gmask[r_i]) begin
            r_i <= r_i + 1'b1;
          end else if (w_ymatch) begin
            r_smask[r_j] <= 1'b1;
            r_yellow     <= r_yellow + 1'b1;
            r_i          <= r_i + 1'b1;
            r_j          <= '0;
          end else if (w_j_last) begin
            r_i <= r_i + 1'b1;
            r_j <= '0;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        WR_HINT: begin
          if (ram_wr_ready) begin
            r_k <= r_k + 1'b1;
            if (w_k_last) r_win <= (r_green == r_n);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_guess_commit_sequencer.sv
// Self-checking bench for guess_commit_sequencer: directed corner cases plus
// randomized commits scored by a plain-arithmetic reference model.
`default_nettype none

module tb_guess_commit_sequencer;
  import guess_commit_sequencer_pkg::*;

  localparam int NP = 20;
  localparam int CW = 5;
  localparam int PW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [PW-1:0]     pins_count;
  logic [7:0]        guess_row;
  logic [NP*CW-1:0]  guess;
  logic [NP*CW-1:0]  secret;
  logic              ram_wr_ready;
  logic              ram_wr_en;
  logic [11:0]       ram_wr_addr;
  logic [CW-1:0]     ram_wr_data;
  logic              busy;
  logic              done;
  logic              err;
  logic [PW-1:0]     green;
  logic [PW-1:0]     yellow;
  logic              win;

  int checks = 0;
  int errors = 0;
  int g[NP];
  int s[NP];

  guess_commit_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .pins_count(pins_count),
    .guess_row(guess_row), .guess(guess), .secret(secret),
    .ram_wr_ready(ram_wr_ready), .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data), .busy(busy), .done(done), .err(err),
    .green(green), .yellow(yellow), .win(win)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load4(input int a0, a1, a2, a3, input int b0, b1, b2, b3);
    for (int p = 0; p < NP; p++) begin g[p] = 0; s[p] = 0; end
    g[0] = a0; g[1] = a1; g[2] = a2; g[3] = a3;
    s[0] = b0; s[1] = b1; s[2] = b2; s[3] = b3;
  endtask

  // Reference scoring: greens first, then each non-green guess pin claims the
  // lowest unclaimed secret pin of the same colour. cyc counts one scan step per cycle.
  function automatic void score(input int n, output int gr, output int ye, output int cyc);
    bit gm[NP];
    bit sm[NP];
    gr = 0; ye = 0; cyc = 0;
    for (int p = 0; p < NP; p++) begin gm[p] = 0; sm[p] = 0; end
    for (int p = 0; p < n; p++)
      if (g[p] == s[p]) begin gm[p] = 1; sm[p] = 1; gr++; end
    for (int a = 0; a < n; a++) begin
      if (gm[a]) begin
        cyc++;
      end else begin
        for (int b = 0; b < n; b++) begin
          cyc++;
          if (!sm[b] && g[a] == s[b]) begin sm[b] = 1; ye++; break; end
        end
      end
    end
  endfunction

  // mode 0: ready high; 1: ready low 3 cycles on the 2nd guess write; 2: random ready
  task automatic run_commit(input string name, input int pins, input int row,
                            input int mode, input bit poke);
    logic [NP*CW-1:0] gv, sv;
    int n, eg, ey, ycyc, base, cyc, stalls, stall_left, nacc;
    bit bad, done_seen, err_seen, prev_hold, busy_bad, rdy, idle_bad;
    logic [11:0] prev_addr;
    logic [CW-1:0] prev_data;
    int ea[$], ed[$], ga[$], gd[$];

    for (int p = 0; p < NP; p++) begin
      gv[p*CW +: CW] = CW'(g[p]);
      sv[p*CW +: CW] = CW'(s[p]);
    end
    n = (pins > NP) ? NP : pins;
    bad = (n > 0) && (row >= 99);
    eg = 0; ey = 0; ycyc = 0;
    if (n > 0 && !bad) begin
      score(n, eg, ey, ycyc);
      for (int p = 0; p < n; p++) begin ea.push_back(row*NP + p); ed.push_back(g[p]); end
      for (int p = 0; p < n; p++) begin
        ea.push_back(1980 + row*NP + p);
        ed.push_back(p < eg ? 2 : (p < eg + ey ? 1 : 0));
      end
      base = 2*n + ycyc + 1;
    end else begin
      base = 1;
    end

    @(negedge clk);
    pins_count = PW'(pins); guess_row = 8'(row); guess = gv; secret = sv;
    start = 1'b1; ram_wr_ready = 1'b1;
    @(posedge clk);
    cyc = 0; stalls = 0; stall_left = 3; nacc = 0;
    done_seen = 0; err_seen = 0; prev_hold = 0; busy_bad = 0;
    prev_addr = '0; prev_data = '0;
    while (!(done_seen || err_seen) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      start = (poke && cyc == 3);
      if (poke && cyc == 3) begin
        guess = ~gv; secret = ~sv; guess_row = 8'd0; pins_count = 5'd7;
      end
      if (mode == 1) begin
        rdy = 1;
        if (nacc == 1 && ram_wr_en && stall_left > 0) begin rdy = 0; stall_left--; end
      end else if (mode == 2) begin
        rdy = ($urandom_range(0, 3) != 0);
      end else begin
        rdy = 1;
      end
      ram_wr_ready = rdy;
      if (prev_hold) begin
        check({name, " held en"}, 32'(ram_wr_en), 32'd1);
        check({name, " held addr"}, 32'(ram_wr_addr), 32'(prev_addr));
        check({name, " held data"}, 32'(ram_wr_data), 32'(prev_data));
      end
      prev_hold = 0;
      if (ram_wr_en) begin
        if (rdy) begin
          ga.push_back(int'(ram_wr_addr)); gd.push_back(int'(ram_wr_data)); nacc++;
        end else begin
          stalls++; prev_hold = 1; prev_addr = ram_wr_addr; prev_data = ram_wr_data;
        end
      end
      if (done) begin
        done_seen = 1;
        check({name, " green"}, 32'(green), 32'(eg));
        check({name, " yellow"}, 32'(yellow), 32'(ey));
        if (n > 0) check({name, " win"}, 32'(win), 32'(eg == n));
        check({name, " busy at done"}, 32'(busy), 32'd0);
      end
      if (err) err_seen = 1;
      if (!done && !err && busy !== 1'b1) busy_bad = 1;
    end
    start = 1'b0;
    check({name, " done seen"}, 32'(done_seen), 32'(!bad));
    check({name, " err seen"}, 32'(err_seen), 32'(bad));
    check({name, " busy during op"}, 32'(busy_bad), 32'd0);
    check({name, " latency"}, 32'(cyc),
          32'(base + (mode == 2 ? stalls : (mode == 1 ? 3 : 0))));
    check({name, " write count"}, 32'(ga.size()), 32'(ea.size()));
    for (int w = 0; w < ea.size() && w < ga.size(); w++) begin
      check($sformatf("%s addr[%0d]", name, w), 32'(ga[w]), 32'(ea[w]));
      check($sformatf("%s data[%0d]", name, w), 32'(gd[w]), 32'(ed[w]));
    end
    idle_bad = 0;
    ram_wr_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ram_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) idle_bad = 1;
    end
    check({name, " idle after"}, 32'(idle_bad), 32'd0);
    check({name, " green held"}, 32'(green), 32'(eg));
    check({name, " yellow held"}, 32'(yellow), 32'(ey));
  endtask

  initial begin
    int cnt;
    bit bad_after;
    logic [NP*CW-1:0] gv, sv;

    reset = 1'b1; start = 1'b0; pins_count = '0; guess_row = '0;
    guess = '0; secret = '0; ram_wr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'({ram_wr_en, busy, done, err, win}), 32'd0);
    check("reset counts", 32'({green, yellow}), 32'd0);
    reset = 1'b0;

    load4(1, 2, 3, 4, 1, 2, 3, 4);
    run_commit("all_green", 4, 0, 0, 0);
    load4(1, 1, 2, 2, 2, 2, 1, 1);
    run_commit("all_yellow", 4, 5, 0, 0);
    load4(1, 1, 1, 1, 1, 2, 3, 4);
    run_commit("duplicates", 4, 17, 0, 0);
    load4(3, 1, 4, 1, 1, 5, 9, 1);
    run_commit("stall_poke", 4, 33, 1, 1);

    for (int p = 0; p < NP; p++) begin g[p] = $urandom_range(0, 3); s[p] = $urandom_range(0, 3); end
    run_commit("row98_n20", 20, 98, 0, 0);
    load4(1, 2, 3, 4, 4, 3, 2, 1);
    run_commit("row99_err", 4, 99, 0, 0);
    run_commit("n_zero", 0, 10, 0, 0);

    // reset while scanning for yellows
    load4(1, 1, 1, 1, 1, 3, 4, 5);
    for (int p = 0; p < NP; p++) begin gv[p*CW +: CW] = CW'(g[p]); sv[p*CW +: CW] = CW'(s[p]); end
    @(negedge clk);
    pins_count = 5'd4; guess_row = 8'd2; guess = gv; secret = sv; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre-reset in yellow", 32'({busy, ram_wr_en}), 32'b10);
    check("pre-reset green", 32'(green), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid reset outputs", 32'({busy, ram_wr_en, done, err}), 32'd0);
    check("mid reset counts", 32'({green, yellow}), 32'd0);
    reset = 1'b0;
    bad_after = 0;
    repeat (25) begin
      @(negedge clk);
      if (ram_wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad_after = 1;
    end
    check("quiet after reset", 32'(bad_after), 32'd0);

    for (int t = 0; t < 14; t++) begin
      for (int p = 0; p < NP; p++) begin g[p] = $urandom_range(0, 3); s[p] = $urandom_range(0, 3); end
      cnt = (t == 5) ? 27 : $urandom_range(1, 20);
      run_commit($sformatf("rand%0d", t), cnt, $urandom_range(0, 98), 2, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
